// File: rtl/alu_op_sequencer_if.sv
// Request/response channels between decode and the ALU sequencer.
// master drives requests and consumes responses.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_opcode;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_cout;
  logic             rsp_err;

  modport master (
    output req_valid,
    output req_opcode,
    output req_a,
    output req_b,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_result,
    input  rsp_cout,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_opcode,
    input  req_a,
    input  req_b,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_result,
    output rsp_cout,
    output rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Control front-end for the bit-slice ALU: single-cycle ops
// plus a shift-add multiply built from repeated ALU adds.
module alu_op_sequencer #(
  parameter int WIDTH     = 16,
  parameter int MUL_STEPS = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_op_sequencer_if.slave bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_ainvert,
  output logic             alu_bnegate,
  output logic             alu_cin,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout
);

  localparam int CW = $clog2(MUL_STEPS + 1);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_NAND = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd7;

  localparam logic [2:0] F_AND = 3'b000;
  localparam logic [2:0] F_OR  = 3'b001;
  localparam logic [2:0] F_ADD = 3'b010;
  localparam logic [2:0] F_XOR = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL,
    RESP
  } state_t;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;

  logic [2:0]       d_op;
  logic             d_inv;
  logic             d_neg;
  logic             d_cin;
  logic             d_ill;
  logic             accept;
  logic             op_arith;
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    d_op  = F_AND;
    d_inv = 1'b0;
    d_neg = 1'b0;
    d_cin = 1'b0;
    d_ill = 1'b0;
    unique case (1'b1)
      (bus.req_opcode == OP_AND):  d_op = F_AND;
      (bus.req_opcode == OP_OR):   d_op = F_OR;
      (bus.req_opcode == OP_ADD):  d_op = F_ADD;
      (bus.req_opcode == OP_SUB): begin
        d_op  = F_ADD;
        d_neg = 1'b1;
        d_cin = 1'b1;
      end
      (bus.req_opcode == OP_XOR):  d_op = F_XOR;
      (bus.req_opcode == OP_NOR): begin
        d_op  = F_AND;
        d_inv = 1'b1;
        d_neg = 1'b1;
      end
      (bus.req_opcode == OP_NAND): begin
        d_op  = F_OR;
        d_inv = 1'b1;
        d_neg = 1'b1;
      end
      (bus.req_opcode == OP_MUL):  d_op = F_ADD;
      default:                     d_ill = 1'b1;
    endcase
  end

  assign accept   = bus.req_valid & bus.req_ready;
  assign op_arith = (op_q == OP_ADD) | (op_q == OP_SUB);

  // During MUL, alu_a holds the accumulator and alu_b the shifted multiplicand
  assign acc_next = mplier[0] ? alu_result : alu_a;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      op_q           <= '0;
      mplier         <= '0;
      cnt            <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_op         <= '0;
      alu_ainvert    <= 1'b0;
      alu_bnegate    <= 1'b0;
      alu_cin        <= 1'b0;
      bus.req_ready  <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_cout   <= 1'b0;
      bus.rsp_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (accept) begin
            bus.req_ready <= 1'b0;
            op_q          <= bus.req_opcode;
            if (bus.req_opcode == OP_MUL) begin
              alu_a  <= '0;
              alu_b  <= bus.req_a;
              alu_op <= F_ADD;
              mplier <= bus.req_b;
              cnt    <= '0;
              state  <= MUL;
            end else begin
              state <= EXEC;
              if (!d_ill) begin
                alu_a       <= bus.req_a;
                alu_b       <= bus.req_b;
                alu_op      <= d_op;
                alu_ainvert <= d_inv;
                alu_bnegate <= d_neg;
                alu_cin     <= d_cin;
              end
            end
          end
        end
        EXEC: begin
          bus.rsp_valid  <= 1'b1;
          bus.rsp_result <= op_q[3] ? '0 : alu_result;
          bus.rsp_cout   <= op_arith & alu_cout;
          bus.rsp_err    <= op_q[3];
          alu_a          <= '0;
          alu_b          <= '0;
          alu_op         <= '0;
          alu_ainvert    <= 1'b0;
          alu_bnegate    <= 1'b0;
          alu_cin        <= 1'b0;
          state          <= RESP;
        end
        MUL: begin
          alu_a  <= acc_next;
          alu_b  <= alu_b << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(MUL_STEPS - 1)) begin
            bus.rsp_valid  <= 1'b1;
            bus.rsp_result <= acc_next;
            bus.rsp_cout   <= 1'b0;
            bus.rsp_err    <= 1'b0;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_op         <= '0;
            state          <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural
// bit-slice ALU closing the loop on the alu_* lines.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_ainvert;
  logic        alu_bnegate;
  logic        alu_cin;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_cout;

  int checks = 0;
  int errors = 0;

  logic [17:0] sb_q[$];

  alu_op_sequencer_if #(.WIDTH(16)) bus ();

  alu_op_sequencer #(
    .WIDTH(16),
    .MUL_STEPS(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ainvert(alu_ainvert),
    .alu_bnegate(alu_bnegate),
    .alu_cin    (alu_cin),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_cout   (alu_cout)
  );

  always #5 clk = ~clk;

  logic [15:0] aa;
  logic [15:0] bb;
  logic [16:0] sum;

  always_comb begin
    aa = alu_ainvert ? ~alu_a : alu_a;
    bb = alu_bnegate ? ~alu_b : alu_b;
    sum = {1'b0, aa} + {1'b0, bb} + {16'd0, alu_cin};
    alu_cout = sum[16];
    case (alu_op)
      3'b000:  alu_result = aa & bb;
      3'b001:  alu_result = aa | bb;
      3'b010:  alu_result = sum[15:0];
      3'b011:  alu_result = aa ^ bb;
      default: alu_result = 16'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {err, cout, result}
  function automatic logic [17:0] model(input logic [3:0] op,
                                       input logic [15:0] a,
                                       input logic [15:0] b);
    logic [31:0] p;
    logic [16:0] s;
    case (op)
      4'd0: return {2'b00, a & b};
      4'd1: return {2'b00, a | b};
      4'd2: begin
        s = {1'b0, a} + {1'b0, b};
        return {1'b0, s};
      end
      4'd3: return {1'b0, a >= b, 16'(a - b)};
      4'd4: return {2'b00, a ^ b};
      4'd5: return {2'b00, ~(a | b)};
      4'd6: return {2'b00, ~(a & b)};
      4'd7: begin
        p = 32'(a) * 32'(b);
        return {2'b00, p[15:0]};
      end
      default: return {1'b1, 17'd0};
    endcase
  endfunction

  // {alu_op, ainvert, bnegate, cin} expected while the op is at the ALU
  function automatic logic [5:0] exp_ctl(input logic [3:0] op);
    case (op)
      4'd0: return 6'b000_000;
      4'd1: return 6'b001_000;
      4'd2: return 6'b010_000;
      4'd3: return 6'b010_011;
      4'd4: return 6'b011_000;
      4'd5: return 6'b000_110;
      4'd6: return 6'b001_110;
      4'd7: return 6'b010_000;
      default: return 6'b000_000;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        check("rsp", {bus.rsp_err, bus.rsp_cout, bus.rsp_result},
              sb_q.pop_front());
      end
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input int hold);
    int n;
    logic [17:0] e;
    logic [5:0] ctl;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready_idle", bus.req_ready, 1);
    e = model(op, a, b);
    sb_q.push_back(e);
    bus.req_valid  = 1'b1;
    bus.req_opcode = op;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.rsp_ready  = (hold == 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    ctl = {alu_op, alu_ainvert, alu_bnegate, alu_cin};
    if (op[3]) begin
      check("alu_idle_ill", {alu_a, alu_b, ctl}, 0);
    end else begin
      check("alu_ctl", ctl, exp_ctl(op));
      if (op == 4'd7) check("alu_ab_mul", {alu_a, alu_b}, {16'd0, a});
      else check("alu_ab", {alu_a, alu_b}, {a, b});
    end
    n = 1;
    while (!bus.rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, (op == 4'd7) ? 17 : 2);
    check("alu_idle_resp", {alu_a, alu_b, alu_op, alu_ainvert,
                            alu_bnegate, alu_cin}, 0);
    check("req_ready_resp", bus.req_ready, 0);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", bus.rsp_valid, 1);
      check("hold_data", {bus.rsp_err, bus.rsp_cout, bus.rsp_result}, e);
      check("hold_req_ready", bus.req_ready, 0);
      bus.req_valid = (i == 2);
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("rsp_valid_done", bus.rsp_valid, 0);
    check("req_ready_back", bus.req_ready, 1);
  endtask

  task automatic reset_mid_mul();
    int seen;
    bus.req_valid  = 1'b1;
    bus.req_opcode = 4'd7;
    bus.req_a      = 16'h1234;
    bus.req_b      = 16'hFFFF;
    bus.rsp_ready  = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_mul_op", alu_op, 3'b010);
    check("mid_mul_valid", bus.rsp_valid, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_alu", {alu_a, alu_b, alu_op, alu_ainvert,
                      alu_bnegate, alu_cin}, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", bus.req_ready, 1);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.rsp_valid) seen++;
      @(posedge clk); #1;
    end
    check("aborted_no_rsp", seen, 0);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_opcode = 4'd2;
    bus.req_a      = 16'h0001;
    bus.req_b      = 16'h0001;
    bus.rsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", bus.req_ready, 0);
    check("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_cout,
                      bus.rsp_result}, 0);
    check("rst_alu_lines", {alu_a, alu_b, alu_op, alu_ainvert,
                            alu_bnegate, alu_cin}, 0);
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    check("first_ready", bus.req_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    check("no_accept_in_reset", {bus.req_ready, bus.rsp_valid}, 2'b10);

    run_op(4'd2, 16'h7FFF, 16'h0001, 0);
    run_op(4'd3, 16'h0005, 16'h0007, 0);
    run_op(4'd3, 16'h0007, 16'h0005, 0);
    run_op(4'd2, 16'hFFFF, 16'h0002, 0);
    run_op(4'd7, 16'h0123, 16'h0011, 0);
    run_op(4'd7, 16'hFFFF, 16'hFFFF, 0);
    run_op(4'd7, 16'h0000, 16'hABCD, 0);
    run_op(4'd0, 16'h0F0F, 16'h00FF, 5);
    repeat (3) @(posedge clk);
    #1;
    check("no_stray_accept", {bus.req_ready, bus.rsp_valid}, 2'b10);
    reset_mid_mul();
    run_op(4'd2, 16'h0001, 16'h0001, 0);
    run_op(4'd5, 16'h00FF, 16'h0F00, 0);
    run_op(4'd6, 16'hFFFF, 16'hFFFF, 0);
    run_op(4'hA, 16'h1234, 16'h5678, 0);
    run_op(4'd1, 16'hA050, 16'h0A05, 2);
    run_op(4'd4, 16'hFF00, 16'h0FF0, 0);
    for (int i = 0; i < 6; i++) begin
      run_op(4'($urandom_range(0, 9)), 16'($urandom), 16'($urandom),
             int'($urandom_range(0, 3)));
    end
    repeat (2) @(posedge clk);
    #1;
    check("sb_left", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
